// File: rtl/dac_xfer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dac_xfer_pkg : shared constants and helpers for the DAC transfer hold |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package dac_xfer_pkg;

    localparam int SWIDTH_DEF    = 16;
    localparam int NSAMP_DEF     = 8;
    localparam int MAX_LOG2R_DEF = 3;

    localparam logic [1:0] MODE_X1 = 2'd0;
    localparam logic [1:0] MODE_X2 = 2'd1;
    localparam logic [1:0] MODE_X4 = 2'd2;
    localparam logic [1:0] MODE_X8 = 2'd3;

    function automatic logic [1:0] clamp_mode(input logic [1:0] mode, input int max_log2r);
        if (int'(mode) > max_log2r) begin
            return 2'(max_log2r);
        end
        return mode;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_hold_expand.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dac_hold_expand : combinational zero-order-hold beat expansion        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module dac_hold_expand #(
    parameter int SWIDTH = 16,
    parameter int NSAMP  = 8,
    parameter int PW     = 3
) (
    input  logic [SWIDTH*NSAMP-1:0] hold_data,
    input  logic [PW-1:0]           phase,
    input  logic [1:0]              ratio_log2,
    output logic [SWIDTH*NSAMP-1:0] beat
);

    for (genvar j = 0; j < NSAMP; j++) begin : g_slot
        logic [31:0]       w_src;
        logic [SWIDTH-1:0] w_sample;

        // Output slot j of this phase is position (phase*NSAMP + j) of the repeated stream
        always_comb begin
            w_src    = ((32'(phase) * 32'(NSAMP)) + 32'(j)) >> ratio_log2;
            w_sample = '0;
            for (int k = 0; k < NSAMP; k++) begin
                if (w_src == 32'(k)) begin
                    w_sample = hold_data[k*SWIDTH +: SWIDTH];
                end
            end
        end

        assign beat[j*SWIDTH +: SWIDTH] = w_sample;
    end

endmodule
`default_nettype wire

// File: rtl/dac_xfer_hold.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dac_xfer_hold : AXI4-Stream to DAC transfer with x1/x2/x4/x8 hold.    |
// | Optional underflow counter: define DAC_XFER_HOLD_UFCNT_EN.            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module dac_xfer_hold
    import dac_xfer_pkg::*;
#(
    parameter int SWIDTH    = SWIDTH_DEF,
    parameter int NSAMP     = NSAMP_DEF,
    parameter int MAX_LOG2R = MAX_LOG2R_DEF
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [1:0]               mode,
    input  logic [SWIDTH*NSAMP-1:0]  s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [SWIDTH*NSAMP-1:0]  m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     underflow
`ifdef DAC_XFER_HOLD_UFCNT_EN
    ,
    input  logic                     clear_count,
    output logic [31:0]              underflow_count
`endif
);

    localparam int BW = SWIDTH * NSAMP;
    localparam int PW = (MAX_LOG2R > 0) ? MAX_LOG2R : 1;

    logic [BW-1:0] hold_q, hold_d;
    logic          hold_valid_q, hold_valid_d;
    logic [1:0]    r_q, r_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          started_q, started_d;
    logic [BW-1:0] tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          underflow_q, underflow_d;

    logic          w_adv;
    logic          w_acc;
    logic          w_last;
    logic [PW-1:0] w_phase_max;
    logic [BW-1:0] w_expanded;

    assign w_phase_max   = PW'((32'd1 << r_q) - 32'd1);
    assign w_last        = (phase_q == w_phase_max);
    assign w_adv         = !tvalid_q || m_axis_tready;
    assign s_axis_tready = !hold_valid_q || (w_adv && w_last);
    assign w_acc         = s_axis_tvalid && s_axis_tready;

    dac_hold_expand #(
        .SWIDTH (SWIDTH),
        .NSAMP  (NSAMP),
        .PW     (PW)
    ) u_expand (
        .hold_data  (hold_q),
        .phase      (phase_q),
        .ratio_log2 (r_q),
        .beat       (w_expanded)
    );

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        r_d          = r_q;
        phase_d      = phase_q;
        started_d    = started_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        underflow_d  = 1'b0;

        if (w_adv) begin
            if (hold_valid_q) begin
                tdata_d  = w_expanded;
                tvalid_d = 1'b1;
                if (w_last) begin
                    hold_valid_d = 1'b0;
                    phase_d      = '0;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end else if (started_q) begin
                tdata_d     = '0;
                tvalid_d    = 1'b1;
                underflow_d = 1'b1;
            end else begin
                tvalid_d = 1'b0;
            end
        end

        // A load may coincide with draining the last phase; the new beat wins the hold register
        if (w_acc) begin
            hold_d       = s_axis_tdata;
            hold_valid_d = 1'b1;
            phase_d      = '0;
            r_d          = clamp_mode(mode, MAX_LOG2R);
            started_d    = 1'b1;
        end
    end

`ifdef DAC_XFER_HOLD_UFCNT_EN
    logic [31:0] ufcnt_q, ufcnt_d;

    always_comb begin
        ufcnt_d = ufcnt_q;
        if (clear_count) begin
            ufcnt_d = '0;
        end else if (underflow_d && (ufcnt_q != 32'hFFFF_FFFF)) begin
            ufcnt_d = ufcnt_q + 32'd1;
        end
    end

    assign underflow_count = ufcnt_q;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            r_q          <= MODE_X1;
            phase_q      <= '0;
            started_q    <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            underflow_q  <= 1'b0;
`ifdef DAC_XFER_HOLD_UFCNT_EN
            ufcnt_q      <= '0;
`endif
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            r_q          <= r_d;
            phase_q      <= phase_d;
            started_q    <= started_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            underflow_q  <= underflow_d;
`ifdef DAC_XFER_HOLD_UFCNT_EN
            ufcnt_q      <= ufcnt_d;
`endif
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign underflow     = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_xfer_hold.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_dac_xfer_hold : randomized bench against a beat-queue model        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_dac_xfer_hold;

    localparam int SW   = 16;
    localparam int NS   = 8;
    localparam int MAXL = 3;
    localparam int BW   = SW * NS;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [BW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [BW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          underflow;
    logic          clear_count = 1'b0;
`ifdef DAC_XFER_HOLD_UFCNT_EN
    logic [31:0]   underflow_count;
`endif

    dac_xfer_hold #(.SWIDTH(SW), .NSAMP(NS), .MAX_LOG2R(MAXL)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .mode          (mode),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .underflow     (underflow)
`ifdef DAC_XFER_HOLD_UFCNT_EN
        ,
        .clear_count     (clear_count),
        .underflow_count (underflow_count)
`endif
    );

    always #5 aclk = ~aclk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: queue of output beats still owed for the current input beat
    logic [BW-1:0] mq[$];
    bit            m_started = 0;
    logic [BW-1:0] m_data = '0;
    bit            m_valid = 0;
    bit            m_uf = 0;
    int unsigned   m_cnt = 0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [BW-1:0] rnd_beat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [BW-1:0] pat_beat(input int b);
        logic [BW-1:0] v;
        for (int k = 0; k < NS; k++) v[k*SW +: SW] = 16'(32'h1000 * b + k);
        return v;
    endfunction

    // Repeat every sample 2^r times in order, then cut the stream into beats
    task automatic push_beats(input logic [BW-1:0] d, input int r);
        logic [SW-1:0] stream[$];
        logic [BW-1:0] beat;
        for (int k = 0; k < NS; k++)
            for (int rep = 0; rep < (1 << r); rep++) stream.push_back(d[k*SW +: SW]);
        while (stream.size() > 0) begin
            for (int j = 0; j < NS; j++) beat[j*SW +: SW] = stream.pop_front();
            mq.push_back(beat);
        end
    endtask

    task automatic cycle(input bit rstn, input bit tv, input logic [BW-1:0] td,
                         input logic [1:0] md, input bit rdy, input bit clr);
        bit exp_ready, adv, acc;
        int r;
        @(negedge aclk);
        aresetn = rstn; s_axis_tvalid = tv; s_axis_tdata = td;
        mode = md; m_axis_tready = rdy; clear_count = clr;
        #1;
        adv       = !m_valid || rdy;
        exp_ready = (mq.size() == 0) || (adv && mq.size() == 1);
        if (rstn) chk("s_tready", BW'(s_axis_tready), BW'(exp_ready));
        acc = tv && exp_ready;
        @(posedge aclk);
        #1;
        if (!rstn) begin
            mq.delete(); m_started = 0; m_data = '0; m_valid = 0; m_uf = 0; m_cnt = 0;
        end else begin
            m_uf = 0;
            if (adv) begin
                if (mq.size() > 0) begin
                    m_data = mq.pop_front(); m_valid = 1;
                end else if (m_started) begin
                    m_data = '0; m_valid = 1; m_uf = 1;
                end else begin
                    m_valid = 0;
                end
            end
            if (acc) begin
                r = (int'(md) > MAXL) ? MAXL : int'(md);
                push_beats(td, r);
                m_started = 1;
            end
            if (clr) m_cnt = 0;
            else if (m_uf && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
        chk("m_tvalid", BW'(m_axis_tvalid), BW'(m_valid));
        chk("m_tdata", m_axis_tdata, m_data);
        chk("underflow", BW'(underflow), BW'(m_uf));
`ifdef DAC_XFER_HOLD_UFCNT_EN
        chk("uf_count", BW'(underflow_count), BW'(m_cnt));
`endif
    endtask

    initial begin
        // Reset, then idle: nothing may come out before the first beat
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 2'd0, 1, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0, '0, 2'd0, 1, 0);
        // x1 streaming
        for (int b = 0; b < 16; b++) cycle(1, 1, pat_beat(b), 2'd0, 1, 0);
        // x4 single beat with samples 0..7
        cycle(1, 1, pat_beat(0), 2'd2, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, '0, 2'd2, 1, 0);
        // Underflow gap of three cycles, then resume
        for (int b = 1; b < 3; b++) cycle(1, 1, pat_beat(b), 2'd0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, '0, 2'd0, 1, 0);
        for (int b = 3; b < 6; b++) cycle(1, 1, pat_beat(b), 2'd0, 1, 0);
        // x2 with a five-cycle DAC stall mid-beat
        cycle(1, 1, pat_beat(7), 2'd1, 1, 0);
        cycle(1, 1, pat_beat(8), 2'd1, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, pat_beat(9), 2'd1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 1, pat_beat(9), 2'd1, 1, 0);
        // x8 beat with a mode switch to x1 partway through
        cycle(1, 1, rnd_beat(), 2'd3, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, '0, 2'd3, 1, 0);
        for (int i = 0; i < 8; i++) cycle(1, 1, pat_beat(10 + i), 2'd0, 1, 0);
        // Fully random traffic with occasional reset and counter clear
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0, rnd_beat(),
                  2'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
                  $urandom_range(0, 149) == 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
